// File: rtl/get_player_inputs.sv
// Connect-4 player control front end: synchronizes, debounces and edge-detects three
// active-low buttons into press pulses, and synchronizes the opponent's command bits.
module get_player_inputs #(
   parameter int N = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left,
   input  logic       right,
   input  logic       put,
   output logic [2:0] lrp_self,
   input  logic       left_data,
   input  logic       right_data,
   input  logic       receive_data,
   output logic [2:0] lrp_opponent
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   // Bit order everywhere is {left, right, put}.
   logic [2:0]            raw;
   logic [2:0]            s1_q, s2_q;
   logic [2:0]            db_q, db_d;
   logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]            lrp_self_q, lrp_self_d;
   logic [2:0]            opp_s1_q, lrp_opp_q;

   assign raw = {left, right, put};

   // Left and right landing together are ambiguous, so both are dropped; put always passes.
   function automatic logic [2:0] resolve_presses(input logic [2:0] press);
      logic [2:0] res;
      res = press;
      if (press[2] && press[1]) begin
         res[2] = 1'b0;
         res[1] = 1'b0;
      end
      return res;
   endfunction

   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i]  = s2_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
      // A press is a debounced 1->0 transition taking effect on this edge.
      lrp_self_d = resolve_presses(db_q & ~db_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q       <= 3'b111;
         s2_q       <= 3'b111;
         db_q       <= 3'b111;
         cnt_q      <= '0;
         lrp_self_q <= 3'b000;
         opp_s1_q   <= 3'b000;
         lrp_opp_q  <= 3'b000;
      end else begin
         s1_q       <= raw;
         s2_q       <= s1_q;
         db_q       <= db_d;
         cnt_q      <= cnt_d;
         lrp_self_q <= lrp_self_d;
         opp_s1_q   <= {left_data, right_data, receive_data};
         lrp_opp_q  <= opp_s1_q;
      end
   end

   assign lrp_self     = lrp_self_q;
   assign lrp_opponent = lrp_opp_q;

endmodule

// File: tb/tb_get_player_inputs.sv
// Scoreboard bench: instance B's press pulses feed instance A's opponent inputs.
module tb_get_player_inputs;

   localparam int N = 3;

   typedef struct {
      logic [2:0] val;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic a_left, a_right, a_put;
   logic b_left, b_right, b_put;
   logic [2:0] a_lrp_self, a_lrp_opp, b_lrp_self, b_lrp_opp;

   int cyc = 0;
   int nchk = 0;
   int nfail = 0;
   bit mon_en = 1'b0;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qo[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   get_player_inputs #(.N(N)) u_a (
      .clk(clk), .rst(rst),
      .left(a_left), .right(a_right), .put(a_put),
      .lrp_self(a_lrp_self),
      .left_data(b_lrp_self[2]), .right_data(b_lrp_self[1]), .receive_data(b_lrp_self[0]),
      .lrp_opponent(a_lrp_opp)
   );

   get_player_inputs #(.N(N)) u_b (
      .clk(clk), .rst(rst),
      .left(b_left), .right(b_right), .put(b_put),
      .lrp_self(b_lrp_self),
      .left_data(1'b0), .right_data(1'b0), .receive_data(1'b0),
      .lrp_opponent(b_lrp_opp)
   );

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_a(input logic [2:0] v, input int at);
      exp_t e;
      e.val = v; e.cyc = at;
      qa.push_back(e);
   endtask

   task automatic push_b(input logic [2:0] v, input int at);
      exp_t e;
      e.val = v; e.cyc = at;
      qb.push_back(e);
      e.cyc = at + 2;
      qo.push_back(e);
   endtask

   // Monitors: every nonzero output must match the head of its queue, value and cycle.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (mon_en && a_lrp_self !== 3'b000) begin
         if (qa.size() == 0) begin
            check_val("a_self_unexpected", {29'd0, a_lrp_self}, 32'd0);
         end else begin
            e = qa.pop_front();
            check_val("a_self_val", {29'd0, a_lrp_self}, {29'd0, e.val});
            check_val("a_self_cyc", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (mon_en && b_lrp_self !== 3'b000) begin
         if (qb.size() == 0) begin
            check_val("b_self_unexpected", {29'd0, b_lrp_self}, 32'd0);
         end else begin
            e = qb.pop_front();
            check_val("b_self_val", {29'd0, b_lrp_self}, {29'd0, e.val});
            check_val("b_self_cyc", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon_o
      exp_t e;
      if (mon_en && a_lrp_opp !== 3'b000) begin
         if (qo.size() == 0) begin
            check_val("a_opp_unexpected", {29'd0, a_lrp_opp}, 32'd0);
         end else begin
            e = qo.pop_front();
            check_val("a_opp_val", {29'd0, a_lrp_opp}, {29'd0, e.val});
            check_val("a_opp_cyc", cyc, e.cyc);
         end
      end
   end

   initial begin
      rst = 1'b1;
      a_left = 1'b1; a_right = 1'b1; a_put = 1'b1;
      b_left = 1'b1; b_right = 1'b1; b_put = 1'b1;

      // Reset state after two reset edges
      tick(2);
      check_val("rst_a_self", {29'd0, a_lrp_self}, 32'd0);
      check_val("rst_a_opp", {29'd0, a_lrp_opp}, 32'd0);
      check_val("rst_b_self", {29'd0, b_lrp_self}, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      tick(6);
      check_val("idle_a_self", {29'd0, a_lrp_self}, 32'd0);
      check_val("idle_a_opp", {29'd0, a_lrp_opp}, 32'd0);
      check_val("idle_b_self", {29'd0, b_lrp_self}, 32'd0);

      // Single left press, held, then released: one pulse only
      a_left = 1'b0; push_a(3'b100, cyc + N + 2);
      tick(10); a_left = 1'b1; tick(10);

      // Right and put together; release right while put held
      a_right = 1'b0; a_put = 1'b0; push_a(3'b011, cyc + N + 2);
      tick(10); a_right = 1'b1; tick(8); a_put = 1'b1; tick(10);

      // Left/right conflict cancels, then left alone pulses
      a_left = 1'b0; a_right = 1'b0;
      tick(10); a_left = 1'b1; a_right = 1'b1; tick(10);
      a_left = 1'b0; push_a(3'b100, cyc + N + 2);
      tick(8); a_left = 1'b1; tick(8);

      // Bounce: two 2-cycle lows split by a 1-cycle high are rejected
      a_left = 1'b0; tick(2); a_left = 1'b1; tick(1);
      a_left = 1'b0; tick(2); a_left = 1'b1; tick(10);
      // Exactly N stable low cycles is accepted
      a_left = 1'b0; push_a(3'b100, cyc + N + 2);
      tick(N); a_left = 1'b1; tick(10);

      // Opponent chain: B presses appear on A.lrp_opponent two edges later
      b_right = 1'b0; push_b(3'b010, cyc + N + 2);
      tick(10); b_right = 1'b1; tick(10);
      b_left = 1'b0; b_put = 1'b0; push_b(3'b101, cyc + N + 2);
      tick(10); b_left = 1'b1; b_put = 1'b1; tick(10);

      // Reset mid-debounce aborts; held button is a fresh press after release
      a_left = 1'b0; tick(2);
      rst = 1'b1; tick(1);
      check_val("midrst_a_self", {29'd0, a_lrp_self}, 32'd0);
      tick(1);
      check_val("midrst_a_self2", {29'd0, a_lrp_self}, 32'd0);
      rst = 1'b0; push_a(3'b100, cyc + N + 2);
      tick(10); a_left = 1'b1; tick(10);

      // Anything still queued never appeared
      while (qa.size() != 0) begin
         void'(qa.pop_front());
         check_val("a_self_missing", 32'd0, 32'd1);
      end
      while (qb.size() != 0) begin
         void'(qb.pop_front());
         check_val("b_self_missing", 32'd0, 32'd1);
      end
      while (qo.size() != 0) begin
         void'(qo.pop_front());
         check_val("a_opp_missing", 32'd0, 32'd1);
      end

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule
